// File: rtl/dmac_engine.sv
// Single-channel word-by-word DMA copy engine.
// Each word is one AR/R read followed by one AW/W/B write, with no overlap between them.
module dmac_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] byte_len_i,
    input  logic             start_i,
    output logic             done_o,
    output logic [31:0]      araddr_o,
    output logic             arvalid_o,
    input  logic             arready_i,
    input  logic [31:0]      rdata_i,
    input  logic             rvalid_i,
    output logic             rready_o,
    output logic [31:0]      awaddr_o,
    output logic             awvalid_o,
    input  logic             awready_i,
    output logic [31:0]      wdata_o,
    output logic             wlast_o,
    output logic             wvalid_o,
    input  logic             wready_i,
    input  logic             bvalid_i,
    output logic             bready_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RREQ  = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WREQ  = 3'd3;
    localparam logic [2:0] WDATA = 3'd4;
    localparam logic [2:0] WRESP = 3'd5;

    localparam logic [LEN_W-3:0] CNT_ONE = 1;

    logic [2:0]       state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      data_q;
    logic [LEN_W-3:0] cnt_q;
    logic [LEN_W-3:0] words;

    // Sub-word length bits are dropped; only whole words are moved.
    assign words = byte_len_i[LEN_W-1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && (words != '0)) begin
                        src_q <= src_addr_i;
                        dst_q <= dst_addr_i;
                        cnt_q <= words;
                        state <= RREQ;
                    end
                end
                RREQ: begin
                    if (arready_i) state <= RDATA;
                end
                RDATA: begin
                    if (rvalid_i) begin
                        data_q <= rdata_i;
                        state  <= WREQ;
                    end
                end
                WREQ: begin
                    if (awready_i) state <= WDATA;
                end
                WDATA: begin
                    if (wready_i) state <= WRESP;
                end
                WRESP: begin
                    if (bvalid_i) begin
                        src_q <= src_q + 32'd4;
                        dst_q <= dst_q + 32'd4;
                        cnt_q <= cnt_q - CNT_ONE;
                        state <= (cnt_q == CNT_ONE) ? IDLE : RREQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register, so reset clears them at once.
    assign done_o    = (state == IDLE);
    assign arvalid_o = (state == RREQ);
    assign rready_o  = (state == RDATA);
    assign awvalid_o = (state == WREQ);
    assign wvalid_o  = (state == WDATA);
    assign wlast_o   = (state == WDATA);
    assign bready_o  = (state == WRESP);

    assign araddr_o  = src_q;
    assign awaddr_o  = dst_q;
    assign wdata_o   = data_q;
endmodule

// File: tb/tb_dmac_engine.sv
// Randomized bench for dmac_engine: a memory slave with optional stalls plus a
// transaction-level model (expected address queues, phase order, source memory) checked every cycle.
module tb_dmac_engine;
    logic        clk, rst_n;
    logic [31:0] src_addr_i, dst_addr_i, rdata_i;
    logic [15:0] byte_len_i;
    logic        start_i, arready_i, rvalid_i, awready_i, wready_i, bvalid_i;
    logic        done_o, arvalid_o, rready_o, awvalid_o, wlast_o, wvalid_o, bready_o;
    logic [31:0] araddr_o, awaddr_o, wdata_o;

    dmac_engine #(.LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .byte_len_i(byte_len_i), .start_i(start_i),
        .done_o(done_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: phase 0 idle, 1 AR, 2 R, 3 AW, 4 W, 5 B
    int          ph = 0;
    logic [31:0] q_ar[$];
    logic [31:0] q_aw[$];
    logic [31:0] cur_src, cur_dst, last_ar, last_aw;
    logic [31:0] mem [logic [31:0]];
    int          busy_cnt = 0;
    bit          stall = 0;
    bit          hit5000 = 0;
    int          dly[1:5];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    function automatic logic [5:0] exp_vec(input int p);
        case (p)
            1: return 6'b100000;
            2: return 6'b010000;
            3: return 6'b001000;
            4: return 6'b000100;
            5: return 6'b000010;
            default: return 6'b000001;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic chan_in(input int k);
        if (!stall) return 1'b1;
        if (ph == k) begin
            if (dly[k] == 0) return 1'b1;
            dly[k]--;
            return 1'b0;
        end
        return 1'($urandom_range(0, 1));
    endfunction

    // Compare process and memory slave: check at negedge, drive just after posedge.
    initial begin
        for (int k = 1; k <= 5; k++) dly[k] = 0;
        arready_i = 0; rvalid_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0; rdata_i = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("ctl", {26'd0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, done_o},
                    {26'd0, exp_vec(ph)});
                chk("wlast", {31'd0, wlast_o}, {31'd0, wvalid_o});
                if (!done_o) busy_cnt++;
                if (arvalid_o && araddr_o[31:12] == 20'h00005) hit5000 = 1;
                case (ph)
                    0: if (start_i && byte_len_i[15:2] != 0) begin
                        for (int i = 0; i < int'(byte_len_i[15:2]); i++) begin
                            q_ar.push_back(src_addr_i + 32'(4 * i));
                            q_aw.push_back(dst_addr_i + 32'(4 * i));
                        end
                        ph = 1;
                    end
                    1: begin
                        chk("araddr", araddr_o, q_ar[0]);
                        if (arready_i) begin
                            cur_src = q_ar.pop_front(); last_ar = cur_src;
                            dly[1] = $urandom_range(0, 7); ph = 2;
                        end
                    end
                    2: if (rvalid_i) begin dly[2] = $urandom_range(0, 7); ph = 3; end
                    3: begin
                        chk("awaddr", awaddr_o, q_aw[0]);
                        if (awready_i) begin
                            cur_dst = q_aw.pop_front(); last_aw = cur_dst;
                            dly[3] = $urandom_range(0, 7); ph = 4;
                        end
                    end
                    4: begin
                        chk("wdata", wdata_o, rd(cur_src));
                        if (wready_i) begin
                            mem[cur_dst] = wdata_o;
                            dly[4] = $urandom_range(0, 7); ph = 5;
                        end
                    end
                    5: if (bvalid_i) begin
                        dly[5] = $urandom_range(0, 7);
                        ph = (q_ar.size() == 0) ? 0 : 1;
                    end
                    default: ph = 0;
                endcase
            end
            @(posedge clk); #1;
            arready_i = chan_in(1);
            rvalid_i  = chan_in(2);
            awready_i = chan_in(3);
            wready_i  = chan_in(4);
            bvalid_i  = chan_in(5);
            rdata_i   = (ph == 2) ? rd(cur_src) : $urandom;
        end
    end

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len);
        @(posedge clk); #1;
        src_addr_i = s; dst_addr_i = d; byte_len_i = len; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_o && ph == 0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        rst_n = 0; start_i = 0; src_addr_i = 0; dst_addr_i = 0; byte_len_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {26'd0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, done_o}, 32'h1);
        rst_n = 1;

        // single word
        mem[32'h1000] = 32'hDEAD_BEEF;
        busy_cnt = 0;
        start_xfer(32'h1000, 32'h2000, 16'd4);
        wait_idle(100);
        chk("single_busy", 32'(busy_cnt), 32'd5);
        chk("single_data", rd(32'h2000), 32'hDEAD_BEEF);
        chk("single_ar", last_ar, 32'h1000);
        chk("single_aw", last_aw, 32'h2000);

        // 64 words, no stalls
        busy_cnt = 0;
        start_xfer(32'h1000, 32'h2000, 16'h0100);
        wait_idle(1000);
        chk("multi_busy", 32'(busy_cnt), 32'd320);
        chk("multi_last_ar", last_ar, 32'h10FC);
        chk("multi_last_aw", last_aw, 32'h20FC);
        for (int i = 0; i < 64; i++)
            chk("multi_mem", rd(32'h2000 + 32'(4 * i)), rd(32'h1000 + 32'(4 * i)));

        // same copy with random backpressure
        stall = 1;
        start_xfer(32'h1000, 32'h3000, 16'h0100);
        wait_idle(6000);
        for (int i = 0; i < 64; i++)
            chk("stall_mem", rd(32'h3000 + 32'(4 * i)), rd(32'h2000 + 32'(4 * i)));
        stall = 0;

        // zero / sub-word lengths
        start_xfer(32'h6000, 32'h7000, 16'd0);
        repeat (4) begin @(posedge clk); #1; chk("len0_done", {31'd0, done_o}, 32'd1); end
        start_xfer(32'h6000, 32'h7000, 16'd3);
        repeat (4) begin @(posedge clk); #1; chk("len3_done", {31'd0, done_o}, 32'd1); end
        chk("len3_nowrite", {31'd0, mem.exists(32'h7000)}, 32'd0);
        busy_cnt = 0;
        start_xfer(32'h1100, 32'h7000, 16'd7);
        wait_idle(100);
        chk("len7_busy", 32'(busy_cnt), 32'd5);
        chk("len7_data", rd(32'h7000), rd(32'h1100));
        chk("len7_one", {31'd0, mem.exists(32'h7004)}, 32'd0);

        // start while busy is ignored; start on done-rise cycle is accepted
        hit5000 = 0;
        start_xfer(32'h1200, 32'h7100, 16'd16);
        repeat (3) @(posedge clk);
        start_xfer(32'h5000, 32'h7200, 16'd16);
        begin
            bit seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (done_o) begin seen = 1; break; end
            end
            chk("busy_done_seen", {31'd0, seen}, 32'd1);
        end
        src_addr_i = 32'h1300; dst_addr_i = 32'h7300; byte_len_i = 16'd8; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        chk("b2b_accept", {31'd0, done_o}, 32'd0);
        wait_idle(200);
        chk("busy_no5000", {31'd0, hit5000}, 32'd0);
        chk("busy_no7200", {31'd0, mem.exists(32'h7200)}, 32'd0);
        for (int i = 0; i < 4; i++)
            chk("busy_mem", rd(32'h7100 + 32'(4 * i)), rd(32'h1200 + 32'(4 * i)));
        for (int i = 0; i < 2; i++)
            chk("b2b_mem", rd(32'h7300 + 32'(4 * i)), rd(32'h1300 + 32'(4 * i)));

        // random transfers with stalls
        stall = 1;
        for (int it = 0; it < 6; it++) begin
            logic [31:0] s, d;
            logic [15:0] len;
            s = 32'h0001_0000 + 32'($urandom_range(0, 255) * 4);
            d = 32'h0004_0000 + 32'(it * 32'h1000);
            len = 16'($urandom_range(0, 40));
            start_xfer(s, d, len);
            wait_idle(2000);
            for (int i = 0; i < int'(len[15:2]); i++)
                chk("rand_mem", rd(d + 32'(4 * i)), rd(s + 32'(4 * i)));
            chk("rand_tail", {31'd0, mem.exists(d + 32'(4 * int'(len[15:2])))}, 32'd0);
        end

        // asynchronous reset while in WDATA
        start_xfer(32'h1000, 32'h9000, 16'h0020);
        begin
            bit seen = 0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (wvalid_o) begin seen = 1; break; end
            end
            chk("rst_reach_w", {31'd0, seen}, 32'd1);
        end
        #1 rst_n = 0;
        #1;
        chk("rst_wvalid", {31'd0, wvalid_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd1);
        ph = 0; q_ar.delete(); q_aw.delete();
        stall = 0;
        @(posedge clk); #1;
        rst_n = 1;
        busy_cnt = 0;
        start_xfer(32'h1000, 32'hA000, 16'd4);
        wait_idle(100);
        chk("post_rst_busy", 32'(busy_cnt), 32'd5);
        chk("post_rst_data", rd(32'hA000), 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmac_engine.md
# dmac_engine

Single-channel DMA transfer engine that sequences word-by-word copies from a source to a destination address over an AXI-style read/write master port. It consumes the `src_addr`/`dst_addr`/`byte_len`/`start` outputs of the DMA configuration block. It reports completion back on `done_o`, which feeds the configuration block's status register. Each word is moved as one read transaction (AR, R) followed by one write transaction (AW, W, B), with no outstanding overlap.

## Interface
- LEN_W, 16, width of byte_len_i.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_addr_i  in  32  source byte address; sampled on accepted start.
- dst_addr_i  in  32  destination byte address; sampled on accepted start.
- byte_len_i  in  LEN_W  transfer length in bytes; sampled on accepted start.
- start_i  in  1  start request; single-cycle pulse expected, level tolerated.
- done_o  out  1  1 while idle, i.e. no transfer in progress.
- araddr_o  out  32  read address.
- arvalid_o  out  1  read address valid.
- arready_i  in  1  read address ready.
- rdata_i  in  32  read data.
- rvalid_i  in  1  read data valid.
- rready_o  out  1  read data ready.
- awaddr_o  out  32  write address.
- awvalid_o  out  1  write address valid.
- awready_i  in  1  write address ready.
- wdata_o  out  32  write data.
- wlast_o  out  1  last write beat; always equal to wvalid_o (single-beat).
- wvalid_o  out  1  write data valid.
- wready_i  in  1  write data ready.
- bvalid_i  in  1  write response valid.
- bready_o  out  1  write response ready.

## Operation
- Transfer unit is one 32-bit word. The word count is `byte_len_i[LEN_W-1:2]`; bits [1:0] are ignored.
- FSM states: IDLE, RREQ, RDATA, WREQ, WDATA, WRESP.
- IDLE: `done_o`=1.
  - On `start_i`=1 with word count ≠ 0: latch src, dst and word count into internal registers, then go to RREQ.
  - On `start_i`=1 with word count = 0: no action; `done_o` stays 1.
- RREQ: `arvalid_o`=1 and `araddr_o`=src register. On `arready_i`, go to RDATA.
- RDATA: `rready_o`=1. On `rvalid_i`, capture `rdata_i` into the data register, then go to WREQ.
- WREQ: `awvalid_o`=1 and `awaddr_o`=dst register. On `awready_i`, go to WDATA.
- WDATA: `wvalid_o`=`wlast_o`=1 and `wdata_o`=data register. On `wready_i`, go to WRESP.
- WRESP: `bready_o`=1. On `bvalid_i`:
  - src += 4 and dst += 4, both 32-bit wrap-around with no carry-out handling.
  - count -= 1.
  - If the count was 1 before the decrement, go to IDLE; otherwise go to RREQ.
- `start_i` is ignored in every state other than IDLE. A new transfer never disturbs one in flight.
- Response codes (rresp/bresp) do not exist on this port; every response is treated as success.
- Once asserted, valid signals are held with stable address/data until their ready is seen. Valid is never withdrawn.
- Address and data outputs are driven from internal registers in all states. Their values outside the valid states are don't-care but registered.

## Timing
- Reset (asynchronous, `rst_n`=0): FSM goes to IDLE and `done_o`=1.
  - All valid/ready outputs reset to 0, and address/data registers reset to 0.
  - A reset mid-transfer aborts the transfer immediately. No handshake completion is attempted.
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.
- `done_o` falls in the cycle after the clock edge that samples an accepted `start_i`. `arvalid_o` rises in that same cycle.
- Each handshake completes on a rising edge where both valid and ready are 1. The next state's outputs appear the following cycle.
- With all ready/valid inputs held at 1, each word takes exactly 5 cycles (RREQ, RDATA, WREQ, WDATA, WRESP). An N-word transfer holds `done_o` low for 5N cycles.
- `done_o` returns to 1 in the cycle after the final `bvalid_i` handshake. A `start_i` presented in that cycle is accepted.
- Ready/valid inputs asserted while the engine is not in the matching state are ignored and have no side effects.

## Test plan
- Reset values: hold `rst_n`=0 → `done_o`=1, all valid/ready outputs 0. Then assert `rst_n`=0 mid-transfer (in WDATA) → `wvalid_o` drops asynchronously and `done_o`=1.
- Single word: src=0x1000, dst=0x2000, len=4, slave always ready, read returns 0xDEADBEEF.
  - Expect one AR at 0x1000 and one AW at 0x2000 with `wdata_o`=0xDEADBEEF and `wlast_o`=1.
  - Expect `done_o` low for exactly 5 cycles.
- Multi-word: src=0x1000, dst=0x2000, len=0x100.
  - Expect 64 read/write pairs with addresses incrementing by 4, the last pair at 0x10FC/0x20FC.
  - Memory model compares destination to source.
  - Expect `done_o` low for 320 cycles.
- Backpressure: random 0–7 cycle delays on `arready_i`, `rvalid_i`, `awready_i`, `wready_i` and `bvalid_i`.
  - Expect valid and address/data stable until each handshake, and the same data result as the no-stall run.
- Zero/odd lengths: len=0 or len=3 with a start pulse → no bus activity and `done_o` stays 1. len=7 → exactly one word is moved.
- Start while busy: pulse `start_i` with new src=0x5000 during an active len=16 transfer → ignored, with no access to 0x5000. Start in the cycle `done_o` returns to 1 → accepted.
